// File: rtl/jtdd_pkg.sv
// Shared definitions for the jtdd object-buffer path: object RAM geometry and
// the copy-engine state encoding.
package jtdd_pkg;

   localparam int         ORAM_AW   = 9;
   localparam logic [8:0] ORAM_LAST = 9'd511;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COPY  = 2'd1,
      FLUSH = 2'd2,
      SWAP  = 2'd3
   } dma_state_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port synchronous RAM: port A read/write, port B read-only.
// A read that coincides with a write to the same address returns the old value.
module jtframe_dual_ram #(
   parameter int DW = 8,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          we_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] data_a,
   output logic [DW-1:0] q_a,
   input  logic [AW-1:0] addr_b,
   output logic [DW-1:0] q_b
);

   logic [DW-1:0] mem [0:2**AW-1];

   always_ff @(posedge clk) begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
      if (we_a) mem[addr_a] <= data_a;
   end

endmodule

// File: rtl/jtdd_objbuf.sv
// Object RAM with a vblank-triggered copy into a shadow buffer for the scanner.
// Define JTDD_OBJBUF_DBUF_EN for a double-buffered shadow (front/back banks).
module jtdd_objbuf
   import jtdd_pkg::*;
#(
   parameter int AW = ORAM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vbl,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_dout,
   input  logic          cpu_we,
   output logic [7:0]    cpu_din,
   input  logic [AW-1:0] oram_addr,
   output logic [7:0]    oram_data,
   output logic          dma_busy
);

   localparam logic [AW-1:0] LAST = (AW == ORAM_AW) ? AW'(ORAM_LAST) : '1;

   dma_state_t    state;
   logic          vbl_l;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] wr_addr;
   logic          wr_en;
   logic [7:0]    src_q;
`ifdef JTDD_OBJBUF_DBUF_EN
   logic          bank;
`endif

   always_ff @(posedge clk) begin
      vbl_l <= vbl;
      if (rst) begin
         state    <= IDLE;
         rd_addr  <= '0;
         wr_addr  <= '0;
         wr_en    <= 1'b0;
         dma_busy <= 1'b0;
`ifdef JTDD_OBJBUF_DBUF_EN
         bank     <= 1'b0;
`endif
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: if (vbl && !vbl_l) begin
               rd_addr  <= '0;
               dma_busy <= 1'b1;
               state    <= COPY;
            end
            COPY: begin
               // source read data lands one cycle later, so the write side trails by one
               wr_addr <= rd_addr;
               wr_en   <= 1'b1;
               rd_addr <= rd_addr + AW'(1);
               if (rd_addr == LAST) state <= FLUSH;
            end
            FLUSH: state <= SWAP;
            SWAP: begin
`ifdef JTDD_OBJBUF_DBUF_EN
               bank     <= ~bank;
`endif
               dma_busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   jtframe_dual_ram #(.DW(8), .AW(AW)) u_src (
      .clk    (clk),
      .we_a   (cpu_we),
      .addr_a (cpu_addr),
      .data_a (cpu_dout),
      .q_a    (cpu_din),
      .addr_b (rd_addr),
      .q_b    (src_q)
   );

`ifdef JTDD_OBJBUF_DBUF_EN
   logic [7:0] sh0_q, sh1_q, sh0_unused, sh1_unused;

   // the back bank (~bank) takes DMA writes; the scanner reads the front bank
   jtframe_dual_ram #(.DW(8), .AW(AW)) u_sh0 (
      .clk    (clk),
      .we_a   (wr_en & bank),
      .addr_a (wr_addr),
      .data_a (src_q),
      .q_a    (sh0_unused),
      .addr_b (oram_addr),
      .q_b    (sh0_q)
   );

   jtframe_dual_ram #(.DW(8), .AW(AW)) u_sh1 (
      .clk    (clk),
      .we_a   (wr_en & ~bank),
      .addr_a (wr_addr),
      .data_a (src_q),
      .q_a    (sh1_unused),
      .addr_b (oram_addr),
      .q_b    (sh1_q)
   );

   assign oram_data = bank ? sh1_q : sh0_q;
`else
   logic [7:0] sh_unused;

   jtframe_dual_ram #(.DW(8), .AW(AW)) u_sh (
      .clk    (clk),
      .we_a   (wr_en),
      .addr_a (wr_addr),
      .data_a (src_q),
      .q_a    (sh_unused),
      .addr_b (oram_addr),
      .q_b    (oram_data)
   );
`endif

endmodule

// File: tb/tb_jtdd_objbuf.sv
// Self-checking bench for jtdd_objbuf; honours JTDD_OBJBUF_DBUF_EN like the design.
module tb_jtdd_objbuf;

   logic       clk = 1'b0;
   logic       rst, vbl, cpu_we, dma_busy;
   logic [8:0] cpu_addr, oram_addr;
   logic [7:0] cpu_dout, cpu_din, oram_data;

   int total = 0;
   int bad   = 0;

   logic [7:0] src_m   [512];
   logic [7:0] front_m [512];
   logic [7:0] scan_q  [$];
`ifdef JTDD_OBJBUF_DBUF_EN
   logic       bank_m = 1'b0;
`endif

   typedef struct {
      logic [8:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;
   vec_t vt [6];

   always #5 clk = ~clk;

   jtdd_objbuf #(.AW(9)) dut (
      .clk       (clk),
      .rst       (rst),
      .vbl       (vbl),
      .cpu_addr  (cpu_addr),
      .cpu_dout  (cpu_dout),
      .cpu_we    (cpu_we),
      .cpu_din   (cpu_din),
      .oram_addr (oram_addr),
      .oram_data (oram_data),
      .dma_busy  (dma_busy)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cpu_write(input int a, input logic [7:0] d);
      cpu_addr = 9'(a);
      cpu_dout = d;
      cpu_we   = 1'b1;
      @(negedge clk);
      cpu_we   = 1'b0;
      src_m[a] = d;
   endtask

   task automatic cpu_read(input int a, output logic [7:0] d);
      cpu_addr = 9'(a);
      @(negedge clk);
      d = cpu_din;
   endtask

   task automatic scan_read(input int a, output logic [7:0] d);
      oram_addr = 9'(a);
      @(negedge clk);
      d = oram_data;
   endtask

   // Starts a copy with a vbl edge and follows it until busy falls.
   // Optional: extra vbl pulse, reset pulse, and one CPU write at cycle offset
   // j relative to the edge cycle N (0 disables). DMA reads address a on N+1+a.
   task automatic run_copy(input int inj_vbl, input int rst_at, input int wr_at,
                           input int wa, input logic [7:0] wd, output int busy_n);
      logic [7:0] snap [512];
      bit done = 0;
      snap = src_m;
      scan_q.delete();
      busy_n = 0;
      vbl = 1'b1;
      @(negedge clk);
      vbl = 1'b0;
      for (int j = 1; j <= 700; j++) begin
         scan_q.push_back(oram_data);
         if (dma_busy) busy_n++;
         else begin
            done = 1;
            break;
         end
         vbl    = (j == inj_vbl);
         rst    = (j == rst_at);
         cpu_we = (j == wr_at);
         if (j == wr_at) begin
            cpu_addr = 9'(wa);
            cpu_dout = wd;
            src_m[wa] = wd;
            if (wa >= j) snap[wa] = wd;
         end
         @(negedge clk);
      end
      vbl = 1'b0; rst = 1'b0; cpu_we = 1'b0;
      check("copy_done", int'(done), 1);
      if (rst_at == 0) begin
         front_m = snap;
`ifdef JTDD_OBJBUF_DBUF_EN
         bank_m = ~bank_m;
`endif
      end else begin
`ifdef JTDD_OBJBUF_DBUF_EN
         bank_m = 1'b0;
`endif
      end
`ifdef JTDD_OBJBUF_DBUF_EN
      check("bank", int'(dut.bank), int'(bank_m));
`endif
   endtask

   initial begin
      int         bn, nmis, a;
      logic [7:0] d;

      vt[0] = '{9'd5,   8'hA5, 8'hA5};
      vt[1] = '{9'd0,   8'h5A, 8'h5A};
      vt[2] = '{9'd511, 8'hC3, 8'hC3};
      vt[3] = '{9'd100, 8'h11, 8'h11};
      vt[4] = '{9'd256, 8'h80, 8'h80};
      vt[5] = '{9'd1,   8'hFF, 8'hFF};

      rst = 1'b1; vbl = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_dout = '0; oram_addr = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", int'(dma_busy), 0);
`ifdef JTDD_OBJBUF_DBUF_EN
      check("reset_bank", int'(dut.bank), 0);
`endif
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 512; i++) cpu_write(i, 8'h00);
      run_copy(0, 0, 0, 0, 8'h00, bn);
      check("busy_len_first", bn, 514);
      run_copy(0, 0, 0, 0, 8'h00, bn);
      check("busy_len_second", bn, 514);

      // table vectors: write, copy, read back through both ports
      foreach (vt[i]) cpu_write(int'(vt[i].addr), vt[i].data);
      run_copy(0, 0, 0, 0, 8'h00, bn);
      foreach (vt[i]) begin
         scan_read(int'(vt[i].addr), d);
         check($sformatf("scan_vec%0d", i), int'(d), int'(vt[i].exp));
         cpu_read(int'(vt[i].addr), d);
         check($sformatf("cpu_vec%0d", i), int'(d), int'(vt[i].exp));
      end

      // CPU write to 100 on the very cycle DMA reads 100: shadow gets old value
      run_copy(0, 0, 101, 100, 8'h3C, bn);
      scan_read(100, d);
      check("rbw_shadow_old", int'(d), 8'h11);
      cpu_read(100, d);
      check("rbw_src_new", int'(d), 8'h3C);
      run_copy(0, 0, 0, 0, 8'h00, bn);
      scan_read(100, d);
      check("rbw_shadow_next", int'(d), 8'h3C);

      // second vbl edge mid-copy is ignored
      run_copy(200, 0, 0, 0, 8'h00, bn);
      check("busy_len_reedge", bn, 514);

      // scanner continuously reads address 0 while it changes 00 -> FF
      cpu_write(0, 8'h00);
      run_copy(0, 0, 0, 0, 8'h00, bn);
      cpu_write(0, 8'hFF);
      oram_addr = '0;
      run_copy(0, 0, 0, 0, 8'h00, bn);
      nmis = 0;
      foreach (scan_q[k]) begin
`ifdef JTDD_OBJBUF_DBUF_EN
         d = (k < 514) ? 8'h00 : 8'hFF;
`else
         d = (k < 3) ? 8'h00 : 8'hFF;
`endif
         if (scan_q[k] !== d) nmis++;
      end
      check("scan_seq_len", scan_q.size(), 515);
      check("scan_seq_mismatches", nmis, 0);

      // reset in the middle of a copy, then a full copy
      run_copy(0, 300, 0, 0, 8'h00, bn);
      check("busy_len_reset", bn, 300);
      check("busy_after_reset", int'(dma_busy), 0);
      run_copy(0, 0, 0, 0, 8'h00, bn);
      check("busy_len_after_reset", bn, 514);
      foreach (vt[i]) begin
         scan_read(int'(vt[i].addr), d);
         check($sformatf("scan_post_rst%0d", i), int'(d), int'(front_m[vt[i].addr]));
      end

      // randomized traffic against the model
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 64; i++)
            cpu_write(int'($urandom_range(0, 511)), 8'($urandom));
         for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 511));
            cpu_read(a, d);
            check("rand_cpu", int'(d), int'(src_m[a]));
         end
         run_copy(0, 0, int'($urandom_range(1, 513)), int'($urandom_range(0, 511)),
                  8'($urandom), bn);
         check("rand_busy_len", bn, 514);
         nmis = 0;
         for (int i = 0; i < 512; i++) begin
            scan_read(i, d);
            if (d !== front_m[i]) nmis++;
         end
         check("rand_shadow_mismatches", nmis, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
